quad_decoder: RTL and testbench

//  Consumes a 2-bit quadrature pair (paddle encoder or joystick-to-quadrature emulator) and

---
 rtl/quad_pkg.sv | 34 +++
 rtl/quad_filter.sv | 55 +++++
 rtl/quad_decoder.sv | 172 +++++++++++++++++
 tb/tb_quad_decoder.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// Shared types and step decoding for the quadrature position decoder.
package quad_pkg;

  localparam int unsigned QUAD_W = 2;
  // Divide-by-4 sub-counter spans -3..+3, so it needs three signed bits.
  localparam int unsigned SUB_W  = 3;

  typedef enum logic {
    UNPRIMED = 1'b0,
    TRACK    = 1'b1
  } fsm_t;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_CW   = 2'd1,
    STEP_CCW  = 2'd2,
    STEP_ERR  = 2'd3
  } step_t;

  // Classify one accepted {A,B} transition; equal codes yield STEP_NONE.
  function automatic step_t decode_step(input logic [QUAD_W-1:0] prev,
                                        input logic [QUAD_W-1:0] cur);
    step_t s;
    s = STEP_NONE;
    case ({prev, cur})
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: s = STEP_CW;
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: s = STEP_CCW;
      4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: s = STEP_ERR;
      default:                                s = STEP_NONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/quad_filter.sv
// Two-flop synchroniser followed by a FILT_CYC-cycle stability filter.
// acc_vld pulses on every cycle a stable candidate is (re)accepted.
module quad_filter
  import quad_pkg::*;
#(
  parameter int unsigned FILT_CYC = 3
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [QUAD_W-1:0] quad,
  output logic [QUAD_W-1:0] acc,
  output logic              acc_vld
);

  localparam int unsigned CNT_W = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYC - 1);

  logic [QUAD_W-1:0] s1;
  logic [QUAD_W-1:0] s2;
  logic [QUAD_W-1:0] cand;
  logic [CNT_W-1:0]  cnt;

  // Bring the asynchronous pair into the CLK domain.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= quad;
      s2 <= s1;
    end
  end

  // Restart the hold count on any change; accept once held long enough.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cand    <= '0;
      cnt     <= '0;
      acc     <= '0;
      acc_vld <= 1'b0;
    end else begin
      acc_vld <= 1'b0;
      if (s2 != cand) begin
        cand <= s2;
        cnt  <= '0;
      end else if (cnt == CNT_LAST) begin
        acc     <= cand;
        acc_vld <= 1'b1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: filtered {A,B} -> bounded position, direction and strobes.
// Optional QUAD_DIV4_EN: one position step per full four-edge cycle.
module quad_decoder
  import quad_pkg::*;
#(
  parameter int unsigned POS_W    = 8,
  parameter int unsigned POS_MIN  = 0,
  parameter int unsigned POS_MAX  = 255,
  parameter int unsigned POS_INIT = 128,
  parameter int unsigned FILT_CYC = 3,
  parameter int unsigned WRAP     = 0
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              clr,
  input  logic [QUAD_W-1:0] quad,
  output logic [POS_W-1:0]  pos,
  output logic              step_cw,
  output logic              step_ccw,
  output logic              dir,
  output logic              err
);

  localparam logic [POS_W-1:0] MIN_V  = POS_W'(POS_MIN);
  localparam logic [POS_W-1:0] MAX_V  = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0] INIT_V = POS_W'(POS_INIT);

  logic [QUAD_W-1:0] acc;
  logic              acc_vld;
  fsm_t              state_q;
  fsm_t              state_d;
  logic [QUAD_W-1:0] prev_q;
  logic [QUAD_W-1:0] prev_d;
  step_t             step_c;
  logic              inc;
  logic              dec;
  logic [POS_W-1:0]  pos_d;
  logic              dir_d;
  logic              err_d;

`ifdef QUAD_DIV4_EN
  localparam logic signed [SUB_W-1:0] SUB_TOP = SUB_W'(3);
  localparam logic signed [SUB_W-1:0] SUB_BOT = SUB_W'(-3);
  logic signed [SUB_W-1:0] sub_q;
  logic signed [SUB_W-1:0] sub_d;
`endif

  quad_filter #(
    .FILT_CYC (FILT_CYC)
  ) u_filter (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .quad    (quad),
    .acc     (acc),
    .acc_vld (acc_vld)
  );

  assign step_c = decode_step(prev_q, acc);

  // FSM state and last accepted code.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= UNPRIMED;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
    end
  end

  // Every acceptance primes/keeps TRACK and refreshes prev, even under clr.
  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    if (acc_vld) begin
      state_d = TRACK;
      prev_d  = acc;
    end
  end

  // Decode the step and compute next position, direction and strobes.
  always_comb begin
    inc   = 1'b0;
    dec   = 1'b0;
    err_d = 1'b0;
    pos_d = pos;
    dir_d = dir;
`ifdef QUAD_DIV4_EN
    sub_d = sub_q;
`endif
    if (!clr && acc_vld && (state_q == TRACK)) begin
      case (step_c)
        STEP_CW: begin
`ifdef QUAD_DIV4_EN
          if (sub_q == SUB_TOP) begin
            sub_d = '0;
            inc   = 1'b1;
          end else begin
            sub_d = sub_q + SUB_W'(1);
          end
`else
          inc = 1'b1;
`endif
        end
        STEP_CCW: begin
`ifdef QUAD_DIV4_EN
          if (sub_q == SUB_BOT) begin
            sub_d = '0;
            dec   = 1'b1;
          end else begin
            sub_d = sub_q - SUB_W'(1);
          end
`else
          dec = 1'b1;
`endif
        end
        STEP_ERR: err_d = 1'b1;
        default:  ;
      endcase
    end

    if (clr) begin
      pos_d = INIT_V;
`ifdef QUAD_DIV4_EN
      sub_d = '0;
`endif
    end else if (inc) begin
      dir_d = 1'b1;
      if (pos == MAX_V) begin
        pos_d = (WRAP != 0) ? MIN_V : MAX_V;
      end else begin
        pos_d = pos + POS_W'(1);
      end
    end else if (dec) begin
      dir_d = 1'b0;
      if (pos == MIN_V) begin
        pos_d = (WRAP != 0) ? MAX_V : MIN_V;
      end else begin
        pos_d = pos - POS_W'(1);
      end
    end
  end

  // Registered outputs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pos      <= INIT_V;
      step_cw  <= 1'b0;
      step_ccw <= 1'b0;
      dir      <= 1'b0;
      err      <= 1'b0;
    end else begin
      pos      <= pos_d;
      step_cw  <= inc;
      step_ccw <= dec;
      dir      <= dir_d;
      err      <= err_d;
    end
  end

`ifdef QUAD_DIV4_EN
  // Edge sub-counter for divide-by-4 resolution.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sub_q <= '0;
    end else begin
      sub_q <= sub_d;
    end
  end
`endif

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: five instances with different init/wrap settings share
// one stimulus; a Gray-index model is compared every cycle, plus literal checks.
module tb_quad_decoder;

  localparam int NDUT = 5;
  localparam int FILT = 3;
  localparam int HMAX = 8192;
`ifdef QUAD_DIV4_EN
  localparam bit DIV4 = 1'b1;
`else
  localparam bit DIV4 = 1'b0;
`endif

  function automatic int init_of(input int g);
    case (g)
      0:       return 128;
      1, 2:    return 254;
      default: return 1;
    endcase
  endfunction

  function automatic int wrap_of(input int g);
    return (g == 2 || g == 4) ? 1 : 0;
  endfunction

  // Position of a code on the clockwise cycle 00->10->11->01.
  function automatic int gidx(input logic [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] cw_seq(input int e);
    case (e)
      0:       return 2'b10;
      1:       return 2'b11;
      2:       return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] ccw_from11(input int e);
    case (e)
      0:       return 2'b10;
      1:       return 2'b00;
      2:       return 2'b01;
      default: return 2'b11;
    endcase
  endfunction

  function automatic int wrap_cw_exp(input int e);
    case (e)
      0:       return 255;
      1:       return 0;
      2:       return 1;
      default: return 2;
    endcase
  endfunction

  logic       CLK;
  logic       RESET_N;
  logic       clr;
  logic [1:0] quad;
  logic [7:0] pos_a [NDUT];
  logic       cw_a  [NDUT];
  logic       ccw_a [NDUT];
  logic       dir_a [NDUT];
  logic       err_a [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    quad_decoder #(
      .POS_W    (8),
      .POS_MIN  (0),
      .POS_MAX  (255),
      .POS_INIT (init_of(g)),
      .FILT_CYC (FILT),
      .WRAP     (wrap_of(g))
    ) u_dut (
      .CLK      (CLK),
      .RESET_N  (RESET_N),
      .clr      (clr),
      .quad     (quad),
      .pos      (pos_a[g]),
      .step_cw  (cw_a[g]),
      .step_ccw (ccw_a[g]),
      .dir      (dir_a[g]),
      .err      (err_a[g])
    );
  end

  int checks = 0;
  int errors = 0;
  bit done   = 1'b0;
  int n_cw, n_ccw, n_err;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Model state
  logic [1:0] qs  [HMAX];
  logic [1:0] s2h [HMAX];
  int         k;
  bit         pend;
  logic [1:0] pend_val;
  bit         primed;
  logic [1:0] mprev;
  int         mpos [NDUT];
  int         msub [NDUT];
  bit         mcw  [NDUT];
  bit         mccw [NDUT];
  bit         mdir [NDUT];
  bit         merr [NDUT];

  task automatic model_top(input int i);
    int d;
    bit up;
    bit take;
    mcw[i]  = 1'b0;
    mccw[i] = 1'b0;
    merr[i] = 1'b0;
    if (clr) begin
      mpos[i] = init_of(i);
      msub[i] = 0;
    end else if (pend && primed && pend_val != mprev) begin
      d = (gidx(pend_val) - gidx(mprev) + 4) % 4;
      if (d == 2) begin
        merr[i] = 1'b1;
      end else begin
        up   = (d == 1);
        take = 1'b1;
        if (DIV4) begin
          msub[i] += up ? 1 : -1;
          if (msub[i] == 4 || msub[i] == -4) msub[i] = 0;
          else take = 1'b0;
        end
        if (take) begin
          mdir[i] = up;
          if (up) mcw[i] = 1'b1;
          else    mccw[i] = 1'b1;
          mpos[i] = mpos[i] + (up ? 1 : -1);
          if (mpos[i] > 255) mpos[i] = (wrap_of(i) != 0) ? 0 : 255;
          if (mpos[i] < 0)   mpos[i] = (wrap_of(i) != 0) ? 255 : 0;
        end
      end
    end
  endtask

  // Advance the model by one CLK edge using the inputs seen at that edge.
  task automatic model_edge();
    bit acc_now;
    if (!RESET_N) begin
      k      = 0;
      pend   = 1'b0;
      primed = 1'b0;
      mprev  = 2'b00;
      s2h[0] = 2'b00;
      for (int i = 0; i < NDUT; i++) begin
        mpos[i] = init_of(i);
        msub[i] = 0;
        mcw[i]  = 1'b0;
        mccw[i] = 1'b0;
        mdir[i] = 1'b0;
        merr[i] = 1'b0;
      end
    end else if (k < HMAX - 1) begin
      k++;
      qs[k]  = quad;
      s2h[k] = (k > 2) ? qs[k-2] : 2'b00;
      for (int i = 0; i < NDUT; i++) model_top(i);
      if (pend) begin
        primed = 1'b1;
        mprev  = pend_val;
      end
      // A value is accepted once the synchronised input showed it FILT+1 edges running.
      acc_now = (k >= FILT);
      if (acc_now) begin
        for (int j = k - FILT; j < k; j++) begin
          if (s2h[j] != s2h[k]) acc_now = 1'b0;
        end
      end
      pend     = acc_now;
      pend_val = s2h[k];
    end
  endtask

  initial begin
    forever begin
      @(posedge CLK);
      model_edge();
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge CLK);
      if (RESET_N && !done) begin
        for (int i = 0; i < NDUT; i++) begin
          check($sformatf("u%0d.pos", i),      int'(pos_a[i]), mpos[i]);
          check($sformatf("u%0d.step_cw", i),  int'(cw_a[i]),  int'(mcw[i]));
          check($sformatf("u%0d.step_ccw", i), int'(ccw_a[i]), int'(mccw[i]));
          check($sformatf("u%0d.dir", i),      int'(dir_a[i]), int'(mdir[i]));
          check($sformatf("u%0d.err", i),      int'(err_a[i]), int'(merr[i]));
        end
      end
    end
  end

  task automatic tick(input int n);
    for (int j = 0; j < n; j++) begin
      @(posedge CLK);
      #1;
      n_cw  += int'(cw_a[0]);
      n_ccw += int'(ccw_a[0]);
      n_err += int'(err_a[0]);
    end
  endtask

  task automatic clear_cnt();
    n_cw  = 0;
    n_ccw = 0;
    n_err = 0;
  endtask

  initial begin
    RESET_N = 1'b0;
    clr     = 1'b0;
    quad    = 2'b10;
    clear_cnt();
    tick(3);
    check("rst_pos",     int'(pos_a[0]), 128);
    check("rst_pos_hi",  int'(pos_a[1]), 254);
    check("rst_step_cw", int'(cw_a[0]),  0);
    check("rst_err",     int'(err_a[0]), 0);
    check("rst_dir",     int'(dir_a[0]), 0);

    // Prime on 10: no strobes, position untouched.
    RESET_N = 1'b1;
    clear_cnt();
    tick(10);
    check("prime_pos", int'(pos_a[0]), 128);
    check("prime_cw",  n_cw,  0);
    check("prime_ccw", n_ccw, 0);
    check("prime_err", n_err, 0);

    // 10->00 is one counter-clockwise edge.
    quad = 2'b00;
    tick(8);
    check("ccw1_pos",      int'(pos_a[0]), DIV4 ? 128 : 127);
    check("ccw1_min_sat",  int'(pos_a[3]), DIV4 ? 1 : 0);
    check("ccw1_min_wrap", int'(pos_a[4]), DIV4 ? 1 : 0);

    // Mid-operation reset returns to reset values before the next edge.
    RESET_N = 1'b0;
    #1;
    check("async_rst_pos",  int'(pos_a[0]), 128);
    check("async_rst_pos4", int'(pos_a[4]), 1);
    tick(2);
    RESET_N = 1'b1;
    tick(10);
    check("reprime_pos", int'(pos_a[0]), 128);

    // Four clockwise edges, each strobe exactly 7 edges after the input change.
    clear_cnt();
    for (int e = 0; e < 4; e++) begin
      quad = cw_seq(e);
      for (int t = 1; t <= 8; t++) begin
        tick(1);
        check($sformatf("cw_lat_e%0d_t%0d", e, t), int'(cw_a[0]),
              int'((t == 7) && (!DIV4 || e == 3)));
      end
      check($sformatf("cw_wrap_e%0d", e), int'(pos_a[2]),
            DIV4 ? ((e == 3) ? 255 : 254) : wrap_cw_exp(e));
      check($sformatf("cw_sat_e%0d", e),  int'(pos_a[1]),
            DIV4 ? ((e == 3) ? 255 : 254) : 255);
    end
    check("cw4_pos", int'(pos_a[0]), DIV4 ? 129 : 132);
    check("cw4_cnt", n_cw, DIV4 ? 1 : 4);
    check("cw4_dir", int'(dir_a[0]), 1);

    // One-cycle glitch is filtered out.
    clear_cnt();
    quad = 2'b10;
    tick(1);
    quad = 2'b00;
    tick(10);
    check("glitch_cw",  n_cw,  0);
    check("glitch_ccw", n_ccw, 0);
    check("glitch_err", n_err, 0);
    check("glitch_pos", int'(pos_a[0]), DIV4 ? 129 : 132);

    // 00->11 is illegal; then 11->01 is a clockwise edge.
    clear_cnt();
    quad = 2'b11;
    for (int t = 1; t <= 8; t++) begin
      tick(1);
      check($sformatf("err_t%0d", t), int'(err_a[0]), int'(t == 7));
    end
    check("err_pos", int'(pos_a[0]), DIV4 ? 129 : 132);
    check("err_cw",  n_cw, 0);
    quad = 2'b01;
    for (int t = 1; t <= 8; t++) begin
      tick(1);
      check($sformatf("after_err_cw_t%0d", t), int'(cw_a[0]), int'((t == 7) && !DIV4));
    end
    check("after_err_pos", int'(pos_a[0]), DIV4 ? 129 : 133);

    // Counter-clockwise 01->11->10->00.
    quad = 2'b11;
    tick(8);
    quad = 2'b10;
    tick(8);
    quad = 2'b00;
    tick(8);
    check("ccw3_pos", int'(pos_a[0]), DIV4 ? 129 : 130);
    check("ccw3_dir", int'(dir_a[0]), DIV4 ? 1 : 0);

    // clr on the same edge as an accepted step wins; prev still follows.
    clear_cnt();
    quad = 2'b10;
    tick(6);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("clr_pos",    int'(pos_a[0]), 128);
    check("clr_cw",     int'(cw_a[0]),  0);
    check("clr_pos_hi", int'(pos_a[1]), 254);
    tick(7);
    check("clr_cnt", n_cw, 0);
    quad = 2'b11;
    tick(8);
    check("post_clr_pos", int'(pos_a[0]), DIV4 ? 128 : 129);

    // Clear, then four counter-clockwise edges.
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("clr2_pos", int'(pos_a[0]), 128);
    tick(2);
    clear_cnt();
    for (int e = 0; e < 4; e++) begin
      quad = ccw_from11(e);
      tick(8);
    end
    check("ccw4_pos",      int'(pos_a[0]), DIV4 ? 127 : 124);
    check("ccw4_cnt",      n_ccw, DIV4 ? 1 : 4);
    check("ccw4_dir",      int'(dir_a[0]), 0);
    check("ccw4_min_sat",  int'(pos_a[3]), 0);
    check("ccw4_min_wrap", int'(pos_a[4]), DIV4 ? 0 : 253);

    tick(4);
    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
